refresh_cmd_arbiter: RTL
========================

# refresh_cmd_arbiter

Command arbiter between the refresher and the per-bank machines of the LPDDR4 memory controller. It shares the single DRAM command slot with the PHY-side command register. Bank machines are served round-robin. A refresh request preempts them and locks the slot until the refresh sequence's last command is accepted. Output is one registered stage with valid/ready backpressure.

## Interface
Parameters:
- NBANK, 8, number of bank-machine requesters (2..8)
- AW, 17, address width
- BAW, 3, bank-address width

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  asynchronous reset, active-high
- ref_cmd_valid  in  1  refresher command valid
- ref_cmd_ready  out  1  refresher command accepted
- ref_cmd_last  in  1  final command of the refresh sequence
- ref_cmd_payload_a  in  AW  refresher address
- ref_cmd_payload_ba  in  BAW  refresher bank
- ref_cmd_payload_cas / _ras / _we  in  1 each  refresher command bits
- bm_cmd_valid  in  NBANK  per-bank valid
- bm_cmd_ready  out  NBANK  per-bank accept, at most one bit set
- bm_cmd_payload_a  in  NBANK*AW  packed addresses, bank i at [i*AW +: AW]
- bm_cmd_payload_ba  in  NBANK*BAW  packed bank addresses
- bm_cmd_payload_cas / _ras / _we  in  NBANK each  per-bank command bits
- out_valid  out  1  registered command valid
- out_ready  in  1  downstream accepts the output
- out_payload_a / _ba / _cas / _ras / _we  out  AW/BAW/1/1/1  registered command
- refresh_active  out  1  refresh owns or is claiming the slot (combinational)
- ref_count  out  16  count of REF commands issued

## Operation
- load = !out_valid | out_ready. The output register captures the granted source only when load=1.
- FSM states:
  - NORMAL (reset state)
  - REFRESH
- NORMAL with ref_cmd_valid=1:
  - Refresher has priority: ref_cmd_ready=load, all bm_cmd_ready=0.
  - If ref_cmd_ready & ref_cmd_last, stay NORMAL.
  - Otherwise go to REFRESH; this also applies when ref is not accepted this cycle because load=0.
- NORMAL with ref_cmd_valid=0:
  - Round-robin among the bm_cmd_valid bits, searching from ptr upward with wrap modulo NBANK.
  - The winner w gets bm_cmd_ready[w]=load.
  - On acceptance, ptr <= (w+1) mod NBANK.
  - ptr resets to 0 and is unchanged when nothing is accepted.
- REFRESH:
  - ref_cmd_ready = ref_cmd_valid & load; all bm_cmd_ready=0, even if ref_cmd_valid deasserts between commands.
  - Return to NORMAL the cycle after an accepted beat with ref_cmd_last=1.
- refresh_active = (state==REFRESH) | ref_cmd_valid.
- Output register: on an accepted source, out_valid <= 1 and the payload is copied. Otherwise, if out_ready, out_valid <= 0. Payload holds while out_valid & !out_ready.
- ref_count increments by 1 on each accepted refresher beat with cas=1, ras=1, we=0 (REF). It is 16-bit and wraps 0xFFFF -> 0.
- Accepted PRE-all beats (ras=1, we=1, cas=0) do not count.
- No DRAM timing checks here: tRP, tRFC and tREFI are enforced by the refresher, tRCD and related timings by the bank machines.

## Timing
- Reset values (asynchronous, immediate on sys_rst):
  - out_valid=0, payload all 0
  - state=NORMAL, ptr=0, ref_count=0
  - all ready outputs are combinational and therefore 0 while out_valid=0 with no valid inputs
- Latency: a source accepted in cycle N appears on out_* in cycle N+1.
- Throughput: one command per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, all readys are 0. The payload is stable until the handshake.
- Simultaneous ref_cmd_valid and bm_cmd_valid in NORMAL: ref wins the same cycle; no bank is accepted.
- Reset asserted mid-REFRESH: state returns to NORMAL and out_valid drops. The refresher is reset by the same sys_rst.

## Test plan
- Reset: hold sys_rst 11 ns, then release with all valids 0 -> out_valid=0, ref_count=0, all readys 0, refresh_active=0.
- Single bank: bm_cmd_valid=8'b0000_0100, a=0x1234, ba=2, ras=1 -> bm_cmd_ready[2]=1 for one cycle; next cycle out_valid=1, out_payload_a=0x1234, ba=2.
- Round-robin: all 8 banks valid continuously with out_ready=1 -> grant order 0,1,...,7,0; each bank served exactly once per 8 cycles.
- Refresh preempt: banks 0..7 valid; refresher issues PRE-all (ras=1, we=1, last=0), ref_cmd_valid low 12 cycles, then REF (cas=1, ras=1, last=1):
  - zero bank grants from the PRE-all acceptance through the REF acceptance
  - refresh_active=1 throughout
  - ref_count=1 after the sequence
  - bank grants resume the cycle after REF is accepted
- Backpressure: out_ready=0 for 5 cycles with banks 3 and 5 valid -> one command held, no readys; on out_ready=1, the next grant proceeds with ptr continuing fairly.
- Async reset mid-refresh: assert sys_rst during the REFRESH gap -> out_valid=0 and state NORMAL immediately. After release, bank grants work with no REF pending.

Source files
------------

// File: rtl/refresh_cmd_arbiter.sv
// rtl/refresh_cmd_arbiter.sv - refresh/bank-machine command slot arbiter with one registered output stage
module refresh_cmd_arbiter #(
  parameter int NBANK = 8,
  parameter int AW    = 17,
  parameter int BAW   = 3
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 ref_cmd_valid,
  output logic                 ref_cmd_ready,
  input  logic                 ref_cmd_last,
  input  logic [AW-1:0]        ref_cmd_payload_a,
  input  logic [BAW-1:0]       ref_cmd_payload_ba,
  input  logic                 ref_cmd_payload_cas,
  input  logic                 ref_cmd_payload_ras,
  input  logic                 ref_cmd_payload_we,
  input  logic [NBANK-1:0]     bm_cmd_valid,
  output logic [NBANK-1:0]     bm_cmd_ready,
  input  logic [NBANK*AW-1:0]  bm_cmd_payload_a,
  input  logic [NBANK*BAW-1:0] bm_cmd_payload_ba,
  input  logic [NBANK-1:0]     bm_cmd_payload_cas,
  input  logic [NBANK-1:0]     bm_cmd_payload_ras,
  input  logic [NBANK-1:0]     bm_cmd_payload_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW-1:0]        out_payload_a,
  output logic [BAW-1:0]       out_payload_ba,
  output logic                 out_payload_cas,
  output logic                 out_payload_ras,
  output logic                 out_payload_we,
  output logic                 refresh_active,
  output logic [15:0]          ref_count
);

  localparam int PW = $clog2(NBANK);

  typedef enum logic {NORMAL = 1'b0, REFRESH = 1'b1} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   nxt_ptr;
  logic            found;
  logic            load;
  logic            ref_acc;
  logic            bm_acc;
  logic            is_ref_cmd;
  logic [AW-1:0]   sel_a;
  logic [BAW-1:0]  sel_ba;
  logic            sel_cas;
  logic            sel_ras;
  logic            sel_we;

  // Slot ownership: refresher claims the slot whenever it is valid or mid-sequence
  always_comb begin
    load           = !out_valid | out_ready;
    refresh_active = (state == REFRESH) | ref_cmd_valid;
    ref_cmd_ready  = ref_cmd_valid & load;
    ref_acc        = ref_cmd_ready;
    is_ref_cmd     = ref_cmd_payload_cas & ref_cmd_payload_ras & !ref_cmd_payload_we;
  end

  // Round-robin pick: banks at or above ptr beat banks below it, lowest index first in each half
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (bm_cmd_valid[i] && (PW'(i) < ptr)) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (bm_cmd_valid[i] && (PW'(i) >= ptr)) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
  end

  // Grant the winning bank and mux its payload
  always_comb begin
    bm_acc       = found & !refresh_active & load;
    bm_cmd_ready = '0;
    if (bm_acc) bm_cmd_ready[win] = 1'b1;
    nxt_ptr = (win == PW'(NBANK - 1)) ? '0 : win + PW'(1);
    sel_a   = '0;
    sel_ba  = '0;
    sel_cas = 1'b0;
    sel_ras = 1'b0;
    sel_we  = 1'b0;
    for (int i = 0; i < NBANK; i++) begin
      if (win == PW'(i)) begin
        sel_a   = bm_cmd_payload_a[i*AW +: AW];
        sel_ba  = bm_cmd_payload_ba[i*BAW +: BAW];
        sel_cas = bm_cmd_payload_cas[i];
        sel_ras = bm_cmd_payload_ras[i];
        sel_we  = bm_cmd_payload_we[i];
      end
    end
  end

  // Arbitration state: refresh lock FSM, round-robin pointer and REF counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= NORMAL;
      ptr       <= '0;
      ref_count <= '0;
    end else begin
      if (state == NORMAL) begin
        if (ref_cmd_valid && !(ref_acc && ref_cmd_last)) state <= REFRESH;
      end else begin
        if (ref_acc && ref_cmd_last) state <= NORMAL;
      end
      if (bm_acc) ptr <= nxt_ptr;
      if (ref_acc && is_ref_cmd) ref_count <= ref_count + 16'd1;
    end
  end

  // Output stage: capture the accepted command, drop valid once it is taken downstream
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out_valid       <= 1'b0;
      out_payload_a   <= '0;
      out_payload_ba  <= '0;
      out_payload_cas <= 1'b0;
      out_payload_ras <= 1'b0;
      out_payload_we  <= 1'b0;
    end else if (ref_acc) begin
      out_valid       <= 1'b1;
      out_payload_a   <= ref_cmd_payload_a;
      out_payload_ba  <= ref_cmd_payload_ba;
      out_payload_cas <= ref_cmd_payload_cas;
      out_payload_ras <= ref_cmd_payload_ras;
      out_payload_we  <= ref_cmd_payload_we;
    end else if (bm_acc) begin
      out_valid       <= 1'b1;
      out_payload_a   <= sel_a;
      out_payload_ba  <= sel_ba;
      out_payload_cas <= sel_cas;
      out_payload_ras <= sel_ras;
      out_payload_we  <= sel_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
